// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and the button/pixel-generator side.
// The controller side is the slave; the generator/overlay side is the master.
interface pong_game_ctrl_if;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       graph_still;
  logic       ball_reset;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic [1:0] text_sel;
  logic       game_over;

  modport master (
    output btn, refr_tick, hit, miss,
    input  graph_still, ball_reset, score_d1, score_d0, balls_left, text_sel, game_over
  );

  modport slave (
    input  btn, refr_tick, hit, miss,
    output graph_still, ball_reset, score_d1, score_d0, balls_left, text_sel, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start/serve/game-over flow, BCD score and ball count.
// Motion freeze and overlay select are decoded straight from the state register.
module pong_game_ctrl #(
  parameter int BALLS        = 3,
  parameter int PAUSE_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [1:0] NEWGAME = 2'd0;
  localparam logic [1:0] PLAY    = 2'd1;
  localparam logic [1:0] NEWBALL = 2'd2;
  localparam logic [1:0] OVER    = 2'd3;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [7:0] PAUSE_INIT = 8'(PAUSE_FRAMES);

  logic [1:0] state,      state_nx;
  logic [3:0] score_d1_q, score_d1_nx;
  logic [3:0] score_d0_q, score_d0_nx;
  logic [1:0] balls_q,    balls_nx;
  logic [7:0] timer_q,    timer_nx;
  logic       ball_reset_q, ball_reset_nx;
  logic       hit_q, miss_q;

  logic btn_pressed;
  logic hit_rise;
  logic miss_rise;

  assign btn_pressed = |bus.btn;
  assign hit_rise    = bus.hit  & ~hit_q;
  assign miss_rise   = bus.miss & ~miss_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_nx      = state;
    score_d1_nx   = score_d1_q;
    score_d0_nx   = score_d0_q;
    balls_nx      = balls_q;
    timer_nx      = timer_q;
    ball_reset_nx = 1'b0;

    case (state)
      NEWGAME: begin
        if (btn_pressed) begin
          state_nx      = PLAY;
          score_d1_nx   = 4'd0;
          score_d0_nx   = 4'd0;
          ball_reset_nx = 1'b1;
        end
      end

      PLAY: begin
        // A miss in the same cycle as a hit takes priority and suppresses the point.
        if (miss_rise) begin
          timer_nx = PAUSE_INIT;
          if (balls_q > 2'd1) begin
            balls_nx = balls_q - 2'd1;
            state_nx = NEWBALL;
          end else begin
            balls_nx = 2'd0;
            state_nx = OVER;
          end
        end else if (hit_rise) begin
          if (score_d0_q == 4'd9) begin
            if (score_d1_q != 4'd9) begin
              score_d0_nx = 4'd0;
              score_d1_nx = score_d1_q + 4'd1;
            end
          end else begin
            score_d0_nx = score_d0_q + 4'd1;
          end
        end
      end

      NEWBALL: begin
        if (timer_q == 8'd0) begin
          if (btn_pressed) begin
            state_nx      = PLAY;
            ball_reset_nx = 1'b1;
          end
        end else if (bus.refr_tick) begin
          timer_nx = timer_q - 8'd1;
        end
      end

      OVER: begin
        if (timer_q == 8'd0) begin
          state_nx = NEWGAME;
          balls_nx = BALLS_INIT;
        end else if (bus.refr_tick) begin
          timer_nx = timer_q - 8'd1;
        end
      end

      default: state_nx = NEWGAME;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= NEWGAME;
      score_d1_q   <= 4'd0;
      score_d0_q   <= 4'd0;
      balls_q      <= BALLS_INIT;
      timer_q      <= 8'd0;
      ball_reset_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      score_d1_q   <= score_d1_nx;
      score_d0_q   <= score_d0_nx;
      balls_q      <= balls_nx;
      timer_q      <= timer_nx;
      ball_reset_q <= ball_reset_nx;
      hit_q        <= bus.hit;
      miss_q       <= bus.miss;
    end
  end

  assign bus.graph_still = (state != PLAY);
  assign bus.text_sel    = (state == NEWGAME) ? 2'b01 :
                           (state == OVER)    ? 2'b10 : 2'b00;
  assign bus.game_over   = (state == OVER);
  assign bus.ball_reset  = ball_reset_q;
  assign bus.score_d1    = score_d1_q;
  assign bus.score_d0    = score_d0_q;
  assign bus.balls_left  = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a game-level model predicts every output
// each cycle, with hand-computed expectations pinning the scenario milestones.
module tb_pong_game_ctrl;

  localparam int BALLS    = 3;
  localparam int PAUSE    = 120;
  localparam int TICK_DIV = 4;

  // {graph_still, ball_reset, d1, d0, balls_left, text_sel, game_over} right after reset
  localparam logic [14:0] RESET_VEC = {1'b1, 1'b0, 4'd0, 4'd0, 2'd3, 2'b01, 1'b0};

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(.BALLS(BALLS), .PAUSE_FRAMES(PAUSE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Game-level reference model: integer score, ball count and pause frames.
  typedef enum {WAIT_START, RALLY, SERVE_PAUSE, END_PAUSE} mode_t;
  mode_t m_mode  = WAIT_START;
  int    m_score = 0;
  int    m_balls = BALLS;
  int    m_pause = 0;
  bit    m_br    = 1'b0;
  bit    m_phit  = 1'b0;
  bit    m_pmiss = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit hr, mr, press;
    if (reset) begin
      m_mode  = WAIT_START;
      m_score = 0;
      m_balls = BALLS;
      m_pause = 0;
      m_br    = 1'b0;
      m_phit  = 1'b0;
      m_pmiss = 1'b0;
    end else begin
      hr    = bus.hit && !m_phit;
      mr    = bus.miss && !m_pmiss;
      press = (bus.btn != 2'b00);
      m_br  = 1'b0;
      case (m_mode)
        WAIT_START: if (press) begin
          m_mode  = RALLY;
          m_score = 0;
          m_br    = 1'b1;
        end
        RALLY: begin
          if (mr) begin
            m_pause = PAUSE;
            m_balls = m_balls - 1;
            m_mode  = (m_balls == 0) ? END_PAUSE : SERVE_PAUSE;
          end else if (hr) begin
            m_score = (m_score >= 99) ? 99 : m_score + 1;
          end
        end
        SERVE_PAUSE: begin
          if (m_pause == 0 && press) begin
            m_mode = RALLY;
            m_br   = 1'b1;
          end else if (m_pause > 0 && bus.refr_tick) begin
            m_pause--;
          end
        end
        END_PAUSE: begin
          if (m_pause == 0) begin
            m_mode  = WAIT_START;
            m_balls = BALLS;
          end else if (bus.refr_tick) begin
            m_pause--;
          end
        end
      endcase
      m_phit  = bus.hit;
      m_pmiss = bus.miss;
    end
  end

  function automatic logic [14:0] exp_vec();
    logic [1:0] ts;
    ts = (m_mode == WAIT_START) ? 2'b01 : (m_mode == END_PAUSE) ? 2'b10 : 2'b00;
    return {m_mode != RALLY, m_br, 4'(m_score / 10), 4'(m_score % 10),
            2'(m_balls), ts, m_mode == END_PAUSE};
  endfunction

  logic [14:0] dut_vec;
  assign dut_vec = {bus.graph_still, bus.ball_reset, bus.score_d1, bus.score_d0,
                    bus.balls_left, bus.text_sel, bus.game_over};

  always @(negedge clk) begin
    if (check_en) check("cycle", {1'b0, dut_vec}, {1'b0, exp_vec()});
  end

  // Frame tick: one-cycle pulse every TICK_DIV cycles, random phase.
  initial begin
    int phase;
    bus.refr_tick = 1'b0;
    phase = $urandom_range(0, TICK_DIV - 1);
    forever begin
      @(posedge clk);
      #2;
      phase = (phase + 1) % TICK_DIV;
      bus.refr_tick = (phase == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_game(input logic [1:0] b);
    bus.btn = b;
    step();
    check("start_ball_reset", 16'(bus.ball_reset), 16'd1);
    check("start_moving", 16'(bus.graph_still), 16'd0);
    check("start_score", {8'h00, bus.score_d1, bus.score_d0}, 16'h0000);
    bus.btn = 2'b00;
    step();
    check("ball_reset_one_cycle", 16'(bus.ball_reset), 16'd0);
  endtask

  task automatic hit_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hit = 1'b1;
      repeat (5) step();
      bus.hit = 1'b0;
      repeat ($urandom_range(1, 4)) step();
    end
  endtask

  task automatic raise_miss(input logic [1:0] exp_balls);
    bus.miss = 1'b1;
    step();
    check("miss_balls_left", 16'(bus.balls_left), 16'(exp_balls));
    check("miss_frozen", 16'(bus.graph_still), 16'd1);
  endtask

  // Random buttons, hits and misses during the pause must all be ignored.
  task automatic serve_pause();
    int n = 0;
    while (m_mode == SERVE_PAUSE && m_pause != 0 && n < 2000) begin
      bus.btn  = 2'($urandom_range(0, 3));
      bus.hit  = 1'($urandom_range(0, 1));
      bus.miss = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.btn  = 2'b00;
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    check("pause_cycles_in_range", 16'(n >= (PAUSE - 1) * TICK_DIV + 1 && n <= PAUSE * TICK_DIV), 16'd1);
    step();
    check("still_paused", {14'd0, bus.graph_still, bus.ball_reset}, 16'b10);
    bus.btn = 2'b10;
    step();
    check("serve_ball_reset", {14'd0, bus.graph_still, bus.ball_reset}, 16'b01);
    bus.btn = 2'b00;
    step();
  endtask

  initial begin
    int n;
    bus.btn  = 2'b00;
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    #1 reset = 1'b1;
    #1 check_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    step();
    check("reset_values", {1'b0, dut_vec}, {1'b0, RESET_VEC});

    repeat (3 * TICK_DIV) step();
    check("idle_text", 16'(bus.text_sel), 16'b01);
    check("idle_still", 16'(bus.graph_still), 16'd1);

    // Game 1: carry and saturation, two serves, then game over.
    start_game(2'b01);
    hit_pulses(12);
    check("score_12", {8'h00, bus.score_d1, bus.score_d0}, 16'h0012);
    hit_pulses(93);
    check("score_sat_99", {8'h00, bus.score_d1, bus.score_d0}, 16'h0099);
    raise_miss(2'd2);
    serve_pause();
    raise_miss(2'd1);
    serve_pause();
    raise_miss(2'd0);
    check("over_flags", {13'd0, bus.text_sel, bus.game_over}, 16'b101);
    bus.miss = 1'b0;
    n = 0;
    while (bus.game_over && n < 3000) begin
      bus.hit = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.hit = 1'b0;
    check("over_timeout", 16'(n < 3000), 16'd1);
    check("newgame_after_over", {8'h00, bus.text_sel, bus.balls_left, bus.score_d1, bus.score_d0},
          {8'h00, 2'b01, 2'd3, 8'h99});

    // Game 2: same-cycle hit and miss, then asynchronous reset during the pause.
    step();
    start_game(2'($urandom_range(1, 3)));
    hit_pulses(3);
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    step();
    check("simul_score", {8'h00, bus.score_d1, bus.score_d0}, 16'h0003);
    check("simul_balls", 16'(bus.balls_left), 16'd2);
    check("simul_newball", {13'd0, bus.graph_still, bus.text_sel}, 16'b100);
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    repeat (40) step();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset", {1'b0, dut_vec}, {1'b0, RESET_VEC});
    step();
    reset = 1'b0;

    // Free-running random play.
    for (int i = 0; i < 600; i++) begin
      bus.btn  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.hit  = ($urandom_range(0, 2) == 0);
      bus.miss = ($urandom_range(0, 39) == 0);
      step();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the pong pixel generator. Decides when the ball and bar move, when the ball is re-served, and when the game ends, based on button presses and the generator's frame tick, hit and miss flags. Keeps a two-digit BCD score and the remaining-ball count for the text/score overlay. Sits between the debounced buttons and the pixel generator/overlay logic, all in the `clk` domain.

## Interface
- `BALLS`, default 3: balls per game, legal range 1..3.
- `PAUSE_FRAMES`, default 120: frames of enforced pause after a miss or game over (2 s at 60 Hz), legal range 1..255.
- `clk` input 1: system/pixel clock.
- `reset` input 1: asynchronous, active-high.
- `btn` input 2: debounced buttons, level-sensitive; "pressed" means `btn != 2'b00`.
- `refr_tick` input 1: one-cycle pulse per frame, from the pixel generator.
- `hit` input 1: ball-bar contact flag from the generator; may stay high for many cycles.
- `miss` input 1: ball passed the right screen edge; may stay high for many cycles.
- `graph_still` output 1: 1 freezes ball and bar motion in the generator.
- `ball_reset` output 1: one-cycle pulse that recentres the ball for a serve.
- `score_d1` output 4: BCD tens digit.
- `score_d0` output 4: BCD units digit.
- `balls_left` output 2: remaining balls.
- `text_sel` output 2: overlay message. 00 none, 01 "press to start", 10 "game over", 11 unused.
- `game_over` output 1: high while in OVER.

## Operation
- **Input edge detection.** `hit` and `miss` are registered once, giving `hit_q` and `miss_q`.
  - Events are `hit_rise = hit & ~hit_q` and `miss_rise = miss & ~miss_q`.
  - Sustained levels never count twice.
- **States.** Four states: NEWGAME, PLAY, NEWBALL, OVER.
- **NEWGAME**
  - Outputs: `graph_still=1`, `text_sel=01`.
  - On btn pressed: go to PLAY, clear score to 00, pulse `ball_reset`.
- **PLAY**
  - Outputs: `graph_still=0`, `text_sel=00`.
  - On `hit_rise` with no `miss_rise`: BCD increment of the score.
    - Units 9 wraps to 0 and carries into tens.
    - 99 saturates at 99.
  - On `miss_rise` with `balls_left > 1`: decrement `balls_left`, load timer with PAUSE_FRAMES, go to NEWBALL.
  - On `miss_rise` with `balls_left == 1`: set `balls_left=0`, load timer, go to OVER.
  - If `hit_rise` and `miss_rise` occur in the same cycle, the miss wins and the score is unchanged.
- **NEWBALL**
  - Outputs: `graph_still=1`, `text_sel=00`.
  - The timer decrements on each `refr_tick` while nonzero.
  - When timer == 0 and btn pressed: go to PLAY and pulse `ball_reset`.
  - Button presses while the timer is nonzero are ignored.
- **OVER**
  - Outputs: `graph_still=1`, `text_sel=10`, `game_over=1`.
  - The timer decrements on `refr_tick`.
  - When timer == 0: go to NEWGAME and reload `balls_left=BALLS`. The score is held until the next start.
- **Input gating.** `hit` and `miss` are ignored outside PLAY. The edge registers still track their inputs.

## Timing
- **Reset values:** state NEWGAME, `graph_still=1`, `ball_reset=0`, `score_d1=0`, `score_d0=0`, `balls_left=BALLS`, `text_sel=01`, `game_over=0`, timer 0, `hit_q=0`, `miss_q=0`.
- Reset asserted mid-game returns to these values immediately, without waiting for a clock edge.
- **Registers:** state, score, `balls_left`, timer and `ball_reset` are registers.
- **Decoded outputs:** `graph_still`, `text_sel` and `game_over` are decoded from the state register and change in the cycle after the transition edge.
- **Button latency:** btn sampled high at edge N puts the new state and `ball_reset=1` in cycle N+1. `ball_reset` is high for exactly one cycle.
- **Miss latency:** `miss` rising at edge N is detected at edge N; the state change and decremented `balls_left` are visible in cycle N+1.
- **Hit latency:** the score updates in the cycle after the `hit` rising edge.
- **Pause length:** the pause lasts exactly PAUSE_FRAMES `refr_tick` pulses after entry. A `refr_tick` in the entry cycle itself is not counted.
- **Timer underflow:** the timer never goes below 0.

## Test plan
- **Reset and start:** release reset, hold btn=00 for 3 frames → stays in NEWGAME with `text_sel=01` and `graph_still=1`. Press btn=01 → next cycle `graph_still=0`, one-cycle `ball_reset`, score 00.
- **Score carry and saturation:**
  - In PLAY, 12 separate `hit` pulses each held 5 cycles → score 1,2 (`d1=1`, `d0=2`).
  - Continue to 105 pulses → saturates at 9,9.
- **Miss and pause:**
  - In PLAY, raise `miss` → `balls_left` 3→2, NEWBALL.
  - btn pressed during frames 1..119 → no effect.
  - After the 120th `refr_tick`, btn → PLAY with `ball_reset` pulse.
- **Game over:**
  - Third miss → `balls_left=0`, `game_over=1`, `text_sel=10`.
  - After 120 ticks → NEWGAME with `balls_left=3` and score retained.
  - Start again → score 00.
- **Simultaneous events:** `hit` and `miss` rising in the same cycle → score unchanged, `balls_left` decremented, NEWBALL.
- **Reset mid-pause:** assert `reset` asynchronously mid-NEWBALL → all outputs at reset values before the next `clk` edge.
